// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC register / instruction-fetch sequencer.
// Optional misaligned-target trap is enabled with PC_FETCH_ALIGN_CHECK_EN.
package pc_fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int WAIT_W = 8;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int PC_STEP_DEF = 4;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        EXEC  = 2'd2,
        ERROR = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bus bundle between the fetch controller (master) and its surroundings: next-PC mux,
// instruction memory and decode. Misalign_Err exists only with PC_FETCH_ALIGN_CHECK_EN.
interface pc_fetch_ctrl_if;
    import pc_fetch_ctrl_pkg::*;

    logic [XLEN-1:0] Next_PC;
    logic            Stall;
    logic            IMem_Ack;
    logic [XLEN-1:0] IMem_Data;
    logic [XLEN-1:0] PC_Out;
    logic [XLEN-1:0] PC_Plus4;
    logic            IMem_Req;
    logic [XLEN-1:0] Instr_Out;
    logic            Instr_Valid;
    logic            Fetch_Timeout;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic            Misalign_Err;

    modport master (
        input  Next_PC, Stall, IMem_Ack, IMem_Data,
        output PC_Out, PC_Plus4, IMem_Req, Instr_Out, Instr_Valid, Fetch_Timeout, Misalign_Err
    );
    modport slave (
        output Next_PC, Stall, IMem_Ack, IMem_Data,
        input  PC_Out, PC_Plus4, IMem_Req, Instr_Out, Instr_Valid, Fetch_Timeout, Misalign_Err
    );
`else
    modport master (
        input  Next_PC, Stall, IMem_Ack, IMem_Data,
        output PC_Out, PC_Plus4, IMem_Req, Instr_Out, Instr_Valid, Fetch_Timeout
    );
    modport slave (
        output Next_PC, Stall, IMem_Ack, IMem_Data,
        input  PC_Out, PC_Plus4, IMem_Req, Instr_Out, Instr_Valid, Fetch_Timeout
    );
`endif

endinterface

// File: rtl/pc_fetch_ctrl_wait_counter.sv
// 8-bit saturating wait counter for outstanding fetch requests, with a terminal flag
// raised in the cycle whose unanswered edge would bring the count to MAX_WAIT.
module pc_fetch_ctrl_wait_counter
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [WAIT_W-1:0] count_r;

    // Count unanswered request cycles; clear has priority, saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer (BOOT -> REQ <-> EXEC, sticky ERROR).
// Define PC_FETCH_ALIGN_CHECK_EN to trap misaligned next-PC values into ERROR.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int              PC_STEP      = PC_STEP_DEF,
    parameter int              MAX_WAIT     = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    pc_fetch_ctrl_if.master bus
);

    fetch_state_e    state_r, state_s;
    logic [XLEN-1:0] pc_r, instr_r;
    logic            req_r, valid_r, timeout_r;
    logic            pc_load_s, instr_load_s, wait_clr_s, wait_en_s, timeout_set_s;
    logic            wait_done_s, misalign_s, misalign_set_s;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic            misalign_r;
    assign misalign_s = !is_word_aligned(bus.Next_PC);
`else
    assign misalign_s = 1'b0;
`endif

    pc_fetch_ctrl_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .clr      (wait_clr_s),
        .en       (wait_en_s),
        .terminal (wait_done_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an ack in the terminal wait cycle beats the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            BOOT:  state_s = REQ;
            REQ: begin
                if (bus.IMem_Ack)     state_s = EXEC;
                else if (wait_done_s) state_s = ERROR;
                else                  state_s = REQ;
            end
            EXEC: begin
                if (bus.Stall)        state_s = EXEC;
                else if (misalign_s)  state_s = ERROR;
                else                  state_s = REQ;
            end
            ERROR: state_s = ERROR;
            default: state_s = BOOT;
        endcase
    end

    // Datapath enables decoded from the current state.
    always_comb begin
        pc_load_s      = 1'b0;
        instr_load_s   = 1'b0;
        wait_clr_s     = 1'b1;
        wait_en_s      = 1'b0;
        timeout_set_s  = 1'b0;
        misalign_set_s = 1'b0;
        case (state_r)
            REQ: begin
                instr_load_s  = bus.IMem_Ack;
                wait_clr_s    = bus.IMem_Ack;
                wait_en_s     = !bus.IMem_Ack;
                timeout_set_s = !bus.IMem_Ack && wait_done_s;
            end
            EXEC: begin
                pc_load_s      = !bus.Stall && !misalign_s;
                misalign_set_s = !bus.Stall && misalign_s;
            end
            default: begin
                wait_clr_s = 1'b1;
            end
        endcase
    end

    // Output and datapath registers; req/valid are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_VECTOR;
            instr_r   <= 32'h0000_0000;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            pc_r      <= pc_load_s ? bus.Next_PC : pc_r;
            instr_r   <= instr_load_s ? bus.IMem_Data : instr_r;
            req_r     <= (state_s == REQ);
            valid_r   <= (state_s == EXEC);
            timeout_r <= timeout_r | timeout_set_s;
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Sticky misaligned-target flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_r | misalign_set_s;
        end
    end

    assign bus.Misalign_Err = misalign_r;
`else
    logic unused_s;
    assign unused_s = misalign_set_s;
`endif

    assign bus.PC_Out        = pc_r;
    assign bus.PC_Plus4      = pc_r + XLEN'(PC_STEP);
    assign bus.IMem_Req      = req_r;
    assign bus.Instr_Out     = instr_r;
    assign bus.Instr_Valid   = valid_r;
    assign bus.Fetch_Timeout = timeout_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a cycle-level behavioural model.
// Honours PC_FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_pc_fetch_ctrl;

    localparam int MAXW = 15;
    localparam int M_BOOT = 0, M_REQ = 1, M_EXEC = 2, M_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    int          m_st, m_wait;
    logic [31:0] m_pc, m_instr;
    logic        m_to, m_mis;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(4), .MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_BOOT; m_wait = 0; m_pc = 32'h0; m_instr = 32'h0; m_to = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge();
        case (m_st)
            M_BOOT: begin m_st = M_REQ; m_wait = 0; end
            M_REQ: begin
                if (bus.IMem_Ack) begin
                    m_instr = bus.IMem_Data; m_st = M_EXEC; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == MAXW) begin m_to = 1'b1; m_st = M_ERR; end
                end
            end
            M_EXEC: begin
                if (!bus.Stall) begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
                    if ((bus.Next_PC % 4) != 0) begin
                        m_mis = 1'b1; m_st = M_ERR;
                    end else begin
                        m_pc = bus.Next_PC; m_st = M_REQ; m_wait = 0;
                    end
`else
                    m_pc = bus.Next_PC; m_st = M_REQ; m_wait = 0;
`endif
                end
            end
            default: m_st = M_ERR;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, bus.PC_Out, m_pc);
        check({tag, ".pc4"}, bus.PC_Plus4, m_pc + 32'd4);
        check({tag, ".req"}, {31'd0, bus.IMem_Req}, {31'd0, m_st == M_REQ});
        check({tag, ".instr"}, bus.Instr_Out, m_instr);
        check({tag, ".valid"}, {31'd0, bus.Instr_Valid}, {31'd0, m_st == M_EXEC});
        check({tag, ".tmo"}, {31'd0, bus.Fetch_Timeout}, {31'd0, m_to});
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check({tag, ".mis"}, {31'd0, bus.Misalign_Err}, {31'd0, m_mis});
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        check_all("rst_rel");
    endtask

    initial begin
        logic [31:0] r;
        bus.Next_PC = 32'h0; bus.Stall = 1'b0; bus.IMem_Ack = 1'b0; bus.IMem_Data = 32'h0;
        model_reset();

        // 1. reset / boot
        do_reset();
        check("boot_pc", bus.PC_Out, 32'h0);
        check("boot_pc4", bus.PC_Plus4, 32'h4);
        check("boot_req0", {31'd0, bus.IMem_Req}, 32'd0);
        step("boot1");
        check("boot_req1", {31'd0, bus.IMem_Req}, 32'd1);

        // 2. sequential fetch, ack in first REQ cycle
        bus.IMem_Ack = 1'b1; bus.IMem_Data = 32'h00A0_0093;
        for (int i = 0; i < 4; i++) begin
            bus.Next_PC = m_pc + 32'd4;
            step("seq");
        end
        check("seq_pc8", bus.PC_Out, 32'h8);
        check("seq_instr", bus.Instr_Out, 32'h00A0_0093);

        // 3. branch with stall
        step("to_exec");
        bus.Stall = 1'b1; bus.Next_PC = 32'h0000_0040;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_pc_held", bus.PC_Out, 32'h8);
        bus.Stall = 1'b0;
        step("branch");
        check("branch_pc", bus.PC_Out, 32'h40);
        check("branch_req", {31'd0, bus.IMem_Req}, 32'd1);

        // 4. timeout, then ack in the terminal cycle
        bus.IMem_Ack = 1'b0;
        for (int i = 0; i < MAXW; i++) step("wait");
        check("tmo_flag", {31'd0, bus.Fetch_Timeout}, 32'd1);
        check("tmo_req", {31'd0, bus.IMem_Req}, 32'd0);
        bus.IMem_Ack = 1'b1; bus.Stall = 1'b1; bus.Next_PC = 32'h100;
        for (int i = 0; i < 3; i++) step("err_hold");
        bus.Stall = 1'b0;
        do_reset();
        bus.IMem_Ack = 1'b0;
        step("bnd_boot");
        for (int i = 0; i < MAXW - 1; i++) step("bnd_wait");
        bus.IMem_Ack = 1'b1; bus.IMem_Data = 32'hDEAD_BEEF;
        step("bnd_ack");
        check("bnd_no_tmo", {31'd0, bus.Fetch_Timeout}, 32'd0);
        check("bnd_instr", bus.Instr_Out, 32'hDEAD_BEEF);

        // 5. async reset mid-fetch at PC 0x20
        bus.IMem_Ack = 1'b0; bus.Next_PC = 32'h20;
        step("to_20");
        check("pc_20", bus.PC_Out, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_pc", bus.PC_Out, 32'h0);
        check("async_req", {31'd0, bus.IMem_Req}, 32'd0);
        check_all("async");
        @(negedge clk);
        rst = 1'b0;
        check_all("async_rel");

        // 6. misaligned branch target
        bus.IMem_Ack = 1'b1;
        step("al_req");
        step("al_exec");
        bus.IMem_Ack = 1'b0; bus.Next_PC = 32'h0000_0042;
        step("al_exit");
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check("al_mis", {31'd0, bus.Misalign_Err}, 32'd1);
        check("al_pc", bus.PC_Out, 32'h0);
        check("al_req0", {31'd0, bus.IMem_Req}, 32'd0);
`else
        check("al_pc", bus.PC_Out, 32'h42);
        check("al_req1", {31'd0, bus.IMem_Req}, 32'd1);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.IMem_Ack  = ($urandom_range(0, 3) == 0);
            bus.IMem_Data = $urandom;
            bus.Stall     = ($urandom_range(0, 2) == 0);
            r = $urandom;
            if ($urandom_range(0, 15) == 0) r[1:0] = 2'b10;
            else r[1:0] = 2'b00;
            bus.Next_PC = r;
            step("rnd");
            if ((m_st == M_ERR) && ($urandom_range(0, 3) == 0)) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
